// File: rtl/alu_pkg.sv
// Shared types and defaults for the serial adder.
// Optional saturation support is selected with the ALU_ADDER_SAT_EN macro
// (see alu_serial_adder.sv).
package alu_pkg;

    // Controller states: wait for operands, add one chunk per cycle, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_CHUNK = 8;

    // Number of BUSY cycles needed to cover a full operand.
    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/alu_chunk_add.sv
// One CHUNK-bit slice of the serial adder: a + b + cin -> {cout, sum}.
// Purely combinational; the top feeds it a different slice every cycle.
module alu_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    // Widen by one bit so the carry out of the slice falls into the MSB.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/alu_serial_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per cycle using a
// single shared alu_chunk_add slice.
//
// Build option: define ALU_ADDER_SAT_EN to add the 'sat' input. When sat is
// latched high and the operation overflows, the result clamps to the most
// positive / most negative value (chosen by the sign of a). Without the macro
// the result always wraps modulo 2^WIDTH.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; a, b, sub (and sat) are sampled
// only on that edge. out_valid is high only in DONE, where sum and flags stay
// stable until out_ready is seen; the controller then returns to IDLE and
// never accepts a new operand on that same edge.
module alu_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ALU_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [1:0]       state_o
);

    localparam int N     = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Operand width must split into whole chunks.
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("alu_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    adder_state_t     state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;          // b already inverted for subtraction
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;
`ifdef ALU_ADDER_SAT_EN
    logic             sat_q;
`endif

    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             last_chunk;
    logic [WIDTH-1:0] raw_d;
    logic [WIDTH-1:0] sum_d;
    logic             overflow_d;
    logic             zero_d;
    logic             negative_d;

    assign op_a       = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign op_b       = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign last_chunk = (idx_q == IDX_W'(N - 1));

    alu_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

    // Merge the current chunk into the partial sum and derive final-cycle flags.
    always_comb begin
        raw_d = sum_q;
        raw_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum;
        // Signed overflow: operands agree in sign but the raw result does not.
        overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_d[WIDTH-1] != a_q[WIDTH-1]);
        sum_d = raw_d;
`ifdef ALU_ADDER_SAT_EN
        if (last_chunk && sat_q && overflow_d) begin
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d     = (sum_d == '0);
        negative_d = sum_d[WIDTH-1];
    end

    // Controller: accept operands, step through chunks, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
`ifdef ALU_ADDER_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;          // +1 completes two's complement
                        idx_q   <= '0;
`ifdef ALU_ADDER_SAT_EN
                        sat_q   <= sat;
`endif
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_cout;
                    if (last_chunk) begin
                        idx_q       <= '0;
                        carry_out_q <= chunk_cout;
                        overflow_q  <= overflow_d;
                        zero_q      <= zero_d;
                        negative_q  <= negative_d;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_alu_serial_adder.sv
// Self-checking bench for alu_serial_adder (WIDTH=32, CHUNK=8).
// Honors ALU_ADDER_SAT_EN when the design is built with it.
module tb_alu_serial_adder;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [1:0]   state_o;

  int n_vec = 0;
  int n_err = 0;

  // Expected {carry_out, overflow, zero, negative, sum}
  logic [W+3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  alu_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
`ifdef ALU_ADDER_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .state_o   (state_o)
  );

  // ---------------- reference model ----------------
  // Integer arithmetic on signed/unsigned views of the operands.
  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic msat);
    longint       sa, sb, sr;
    logic [63:0]  ua, ub;
    logic [W-1:0] res;
    logic         c, o;
    sa = $signed(ma);
    sb = $signed(mb);
    sr = msub ? (sa - sb) : (sa + sb);
    o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    c  = msub ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
    res = msub ? (ma - mb) : (ma + mb);
    if (msat && o) res = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {c, o, (res == '0), res[W-1], res};
  endfunction

  function automatic logic rnd_sat();
`ifdef ALU_ADDER_SAT_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W+3:0] observed();
    return {carry_out, overflow, zero, negative, sum};
  endfunction

  // ---------------- driver tasks ----------------
  // Present one operand set for a single accepting edge, then scramble inputs.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tsat);
    @(negedge clk);
    in_valid = 1'b1;
    a = ta; b = tb; sub = tsub; sat = tsat;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_out(output int lat, output bit timed_out);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = (out_valid !== 1'b1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, state_o, observed()} !== {1'b1, 1'b0, 2'd0, {(W+4){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b st=%0d res=%h, want rdy=1 vld=0 st=0 res=0",
               in_ready, out_valid, state_o, observed());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed corner vectors followed by random operations, one at a time.
  task automatic test_single_ops();
    logic [W-1:0] ta[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000};
    logic [W-1:0] tb[5] = '{32'd1,         32'd1,         32'd5, 32'd5, 32'd1};
    logic         ts[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] xa, xb;
    logic         xs, xt;
    logic [W+3:0] e;
    int           lat;
    bit           to;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin
        xa = ta[i]; xb = tb[i]; xs = ts[i];
`ifdef ALU_ADDER_SAT_EN
        xt = (i == 0) ? 1'b1 : 1'b0;
`else
        xt = 1'b0;
`endif
      end else begin
        xa = $urandom; xb = $urandom; xs = 1'($urandom_range(0, 1)); xt = rnd_sat();
        if (i % 5 == 0) xb = xa;                        // zero result
        if (i % 5 == 1) begin xa = 32'h7FFF_FF00; xb = 32'h0000_0200; end
      end
      e = model(xa, xb, xs, xt);
      start_op(xa, xb, xs, xt);
      wait_out(lat, to);
      n_vec++;
      if (to || lat != LAT) begin
        n_err++;
        $display("FAIL op%0d_latency: got %0d cycles (timeout=%0d), want %0d", i, lat, to, LAT);
      end
      @(negedge clk);
      n_vec++;
      if (observed() !== e) begin
        n_err++;
        $display("FAIL op%0d_result a=%h b=%h sub=%b sat=%b: got c/o/z/n/sum=%h, want %h",
                 i, xa, xb, xs, xt, observed(), e);
      end
      release_result();
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL op%0d_release: got rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  // Result held while out_ready stays low; in_valid pulses ignored.
  task automatic test_hold();
    logic [W-1:0] xa, xb;
    logic         xs, xt;
    logic [W+3:0] e;
    int           lat;
    bit           to;
    xa = $urandom; xb = $urandom; xs = 1'($urandom_range(0, 1)); xt = rnd_sat();
    e = model(xa, xb, xs, xt);
    start_op(xa, xb, xs, xt);
    wait_out(lat, to);
    n_vec++;
    if (to || lat != LAT) begin
      n_err++;
      $display("FAIL hold_latency: got %0d (timeout=%0d), want %0d", lat, to, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, observed()} !== {1'b0, 1'b1, e}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got rdy=%b vld=%b res=%h, want rdy=0 vld=1 res=%h",
                 i, in_ready, out_valid, observed(), e);
      end
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    end
    // Release with in_valid still high: must not be taken on the DONE edge.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_o !== 2'd0) begin
      n_err++;
      $display("FAIL hold_exit: got rdy=%b vld=%b st=%0d, want rdy=1 vld=0 st=0",
               in_ready, out_valid, state_o);
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_no_ghost: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  // Reset asserted during the second BUSY cycle discards the operation.
  task automatic test_reset_mid_busy();
    int  lat;
    bit  to;
    int  seen;
    start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {(W+4){1'b0}}}) begin
      n_err++;
      $display("FAIL midreset_clear: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=0",
               out_valid, in_ready, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midreset_quiet: got %0d cycles with vld=1 or rdy=0, want 0", seen);
    end
    start_op(32'h10, 32'h20, 1'b0, 1'b0);
    wait_out(lat, to);
    @(negedge clk);
    n_vec++;
    if (to || lat != LAT || sum !== 32'h30) begin
      n_err++;
      $display("FAIL midreset_next: got sum=%h lat=%0d timeout=%0d, want sum=00000030 lat=%0d",
               sum, lat, to, LAT);
    end
    release_result();
  endtask

  // Continuous traffic: one result every LAT+2 cycles, inputs churn every cycle.
  task automatic test_back_to_back();
    int           cyc, last, nres, nacc;
    logic [W+3:0] e;
    exp_q.delete();
    cyc = 0; last = -1; nres = 0; nacc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (nres < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: result %h with empty queue", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            n_err++;
            $display("FAIL b2b_result%0d: got %h, want %h", nres, observed(), e);
          end
        end
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != LAT + 2) begin
            n_err++;
            $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d", nres, cyc - last, LAT + 2);
          end
        end
        last = cyc;
        nres++;
      end
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); sat = rnd_sat();
      if (in_ready === 1'b1) begin
        if (nacc < 8) begin
          exp_q.push_back(model(a, b, sub, sat));
          nacc++;
        end
        if (nacc >= 8 && exp_q.size() > 0 && in_ready === 1'b1 && nacc == 8 && last >= 0) begin
          in_valid = in_valid;
        end
      end
      if (nacc >= 8 && in_ready !== 1'b1) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (nres != 8 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, %0d left queued, want 8 and 0", nres, exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_ops();
    test_hold();
    test_reset_mid_busy();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
